linear_cordic_unit: RTL

Parametrised, fully pipelined linear-CORDIC engine for the Nth-root floating-point datapath. One iteration per stage; each transaction selects vectoring mode (division, z = y/x, used for the reciprocal/mantissa quotient) or rotation mode (multiplication, y = y0 + x·z). A biased exponent travels alongside the mantissa and leaves unbiased. Adds over the previous fixed reciprocal unit: configurable width, fraction bits, depth and bias; per-transaction mode; valid/ready flow control with stall; asynchronous reset; convergence-error flag.

---
 rtl/linear_cordic_unit_if.sv | 34 +++
 rtl/linear_cordic_unit.sv | 131 +++++++++++++
 2 files changed

// File: rtl/linear_cordic_unit_if.sv
// Handshake bundle for linear_cordic_unit: one input channel (operands, mode,
// biased exponent) and one output channel (results, unbiased exponent, error flag).
interface linear_cordic_unit_if #(
  parameter int W  = 36,
  parameter int EW = 8
);
  // Valid/ready: a transfer happens on a rising clk edge where valid && ready.
  // A producer holding valid may not assume acceptance until it sees ready;
  // the unit keeps out_* stable while out_valid && !out_ready.
  logic          in_valid;
  logic          in_ready;
  logic          in_mode;
  logic [W-1:0]  in_x;
  logic [W-1:0]  in_y;
  logic [W-1:0]  in_z;
  logic [EW-1:0] in_exp;
  logic          out_valid;
  logic          out_ready;
  logic          out_mode;
  logic [W-1:0]  out_y;
  logic [W-1:0]  out_z;
  logic [EW:0]   out_exp;
  logic          out_err;

  modport master (
    output in_valid, in_mode, in_x, in_y, in_z, in_exp, out_ready,
    input  in_ready, out_valid, out_mode, out_y, out_z, out_exp, out_err
  );

  modport slave (
    input  in_valid, in_mode, in_x, in_y, in_z, in_exp, out_ready,
    output in_ready, out_valid, out_mode, out_y, out_z, out_exp, out_err
  );
endinterface

// File: rtl/linear_cordic_unit.sv
// Fully pipelined linear CORDIC: mode 0 divides (z += y/x), mode 1 multiplies
// (y += x*z). One iteration per stage, global stall, exponent unbiased en route.
module linear_cordic_unit #(
  parameter int W      = 36,
  parameter int FRAC   = 27,
  parameter int STAGES = 24,
  parameter int EW     = 8,
  parameter int BIAS   = 127
) (
  input  logic               clk,
  input  logic               rst,
  linear_cordic_unit_if.slave bus
);

  localparam logic signed [W+1:0] TWO_ONE = (W+2)'(1) << (FRAC + 1);

  // Iteration step ONE >> j, which drops to zero once j exceeds FRAC.
  function automatic logic signed [W-1:0] step_of(input int j);
    if (j > FRAC) return '0;
    return W'(1) << (FRAC - j);
  endfunction

  logic adv;

  // Index 0 is the capture register; index j+1 holds the result of iteration j.
  logic                v_r  [0:STAGES];
  logic                m_r  [0:STAGES];
  logic                e_r  [0:STAGES];
  logic [EW:0]         ex_r [0:STAGES];
  logic signed [W-1:0] x_r  [0:STAGES];
  logic signed [W-1:0] y_r  [0:STAGES];
  logic signed [W-1:0] z_r  [0:STAGES];

  logic                dir_n [0:STAGES-1];
  logic signed [W-1:0] y_n   [0:STAGES-1];
  logic signed [W-1:0] z_n   [0:STAGES-1];

  logic                out_valid_r;
  logic                out_mode_r;
  logic                out_err_r;
  logic [W-1:0]        out_y_r;
  logic [W-1:0]        out_z_r;
  logic [EW:0]         out_exp_r;

  logic signed [W+1:0] ext_x, ext_y, ext_z, abs_y, abs_z, two_x;
  logic                cap_err;
  logic [EW:0]         cap_exp;

  assign adv          = ~out_valid_r | bus.out_ready;
  assign bus.in_ready = adv;

  // Convergence check on widened operands so 2*x and |y| cannot wrap.
  always_comb begin
    ext_x   = {{2{bus.in_x[W-1]}}, bus.in_x};
    ext_y   = {{2{bus.in_y[W-1]}}, bus.in_y};
    ext_z   = {{2{bus.in_z[W-1]}}, bus.in_z};
    abs_y   = ext_y[W+1] ? -ext_y : ext_y;
    abs_z   = ext_z[W+1] ? -ext_z : ext_z;
    two_x   = ext_x <<< 1;
    cap_err = 1'b0;
    if (bus.in_mode) cap_err = (abs_z >= TWO_ONE);
    else             cap_err = ext_x[W+1] || (bus.in_x == '0) || (abs_y >= two_x);
    cap_exp = {1'b0, bus.in_exp} - (EW+1)'(BIAS);
  end

  always_comb begin
    for (int j = 0; j < STAGES; j++) begin
      dir_n[j] = m_r[j] ? ~z_r[j][W-1] : (y_r[j][W-1] || (y_r[j] == '0));
      y_n[j]   = y_r[j];
      z_n[j]   = z_r[j];
      if (dir_n[j]) begin
        y_n[j] = y_r[j] + (x_r[j] >>> j);
        z_n[j] = z_r[j] - step_of(j);
      end else begin
        y_n[j] = y_r[j] - (x_r[j] >>> j);
        z_n[j] = z_r[j] + step_of(j);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j <= STAGES; j++) begin
        v_r[j]  <= 1'b0;
        m_r[j]  <= 1'b0;
        e_r[j]  <= 1'b0;
        ex_r[j] <= '0;
        x_r[j]  <= '0;
        y_r[j]  <= '0;
        z_r[j]  <= '0;
      end
      out_valid_r <= 1'b0;
      out_mode_r  <= 1'b0;
      out_err_r   <= 1'b0;
      out_y_r     <= '0;
      out_z_r     <= '0;
      out_exp_r   <= '0;
    end else if (adv) begin
      v_r[0]  <= bus.in_valid;
      m_r[0]  <= bus.in_mode;
      e_r[0]  <= cap_err;
      ex_r[0] <= cap_exp;
      x_r[0]  <= bus.in_x;
      y_r[0]  <= bus.in_y;
      z_r[0]  <= bus.in_z;
      for (int j = 0; j < STAGES; j++) begin
        v_r[j+1]  <= v_r[j];
        m_r[j+1]  <= m_r[j];
        e_r[j+1]  <= e_r[j];
        ex_r[j+1] <= ex_r[j];
        x_r[j+1]  <= x_r[j];
        y_r[j+1]  <= y_n[j];
        z_r[j+1]  <= z_n[j];
      end
      out_valid_r <= v_r[STAGES];
      out_mode_r  <= m_r[STAGES];
      out_err_r   <= e_r[STAGES];
      out_y_r     <= y_r[STAGES];
      out_z_r     <= z_r[STAGES];
      out_exp_r   <= ex_r[STAGES];
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.out_mode  = out_mode_r;
  assign bus.out_err   = out_err_r;
  assign bus.out_y     = out_y_r;
  assign bus.out_z     = out_z_r;
  assign bus.out_exp   = out_exp_r;

endmodule
